// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch / operand / execute control FSM for the 8-bit
// accumulator datapath. Only the state register is sequential; every
// control output is decoded from the state, the IR opcode and the ACC
// zero flag.
// Optional build macro: CTRL_SINGLE_STEP_EN adds the 'step' input and
// gates each fetch on a step pulse.
module ctrl_sequencer #(
   parameter int N = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] opcode,
   input  logic       zero,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic       sclr,
   output logic       pc_out,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       mar_en,
   output logic       ir_en,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       acc_en,
   output logic       acc_out,
   output logic [1:0] alu_op,
   output logic       busy,
   output logic       halted,
   output logic       illegal
);

   // The bus width only matters to the datapath; it must hold BUS[7:3].
   if (N < 8) begin : g_bus_too_narrow
   end

   typedef enum logic [4:0] {
      OP_NOP = 5'b00000,
      OP_LDA = 5'b00001,
      OP_STA = 5'b00010,
      OP_ADD = 5'b00011,
      OP_SUB = 5'b00100,
      OP_JMP = 5'b00101,
      OP_JZ  = 5'b00110,
      OP_HLT = 5'b11111
   } opcode_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_F0,
`ifdef CTRL_SINGLE_STEP_EN
      S_F0GO,
`endif
      S_F1,
      S_DEC,
      S_OPR,
      S_EXE,
      S_HALT
   } state_t;

   state_t state_q, state_d;

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state and control-word decode.
   always_comb begin
      state_d = state_q;
      sclr    = 1'b0;
      pc_out  = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      mar_en  = 1'b0;
      ir_en   = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      acc_en  = 1'b0;
      acc_out = 1'b0;
      alu_op  = 2'b00;
      illegal = 1'b0;
      halted  = 1'b0;
      busy    = (state_q != S_IDLE) && (state_q != S_HALT);
      unique case (state_q)
         S_IDLE: if (start) state_d = S_CLEAR;
         S_CLEAR: begin
            sclr    = 1'b1;
            state_d = S_F0;
         end
`ifdef CTRL_SINGLE_STEP_EN
         // F0 waits quietly for a step; the address phase runs in F0GO.
         S_F0: if (step) state_d = S_F0GO;
         S_F0GO: begin
            pc_out  = 1'b1;
            mar_en  = 1'b1;
            state_d = S_F1;
         end
`else
         S_F0: begin
            pc_out  = 1'b1;
            mar_en  = 1'b1;
            state_d = S_F1;
         end
`endif
         S_F1: begin
            mem_rd  = 1'b1;
            ir_en   = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_DEC;
         end
         S_DEC: begin
            unique case (opcode)
               OP_NOP: state_d = S_F0;
               OP_HLT: state_d = S_HALT;
               OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP, OP_JZ: begin
                  pc_out  = 1'b1;
                  mar_en  = 1'b1;
                  state_d = S_OPR;
               end
               default: begin
                  illegal = 1'b1;
                  state_d = S_F0;
               end
            endcase
         end
         S_OPR: begin
            state_d = S_F0;
            if (opcode == OP_JMP || (opcode == OP_JZ && zero)) begin
               mem_rd  = 1'b1;
               pc_load = 1'b1;
            end else if (opcode == OP_JZ) begin
               pc_inc = 1'b1;
            end else begin
               mem_rd  = 1'b1;
               mar_en  = 1'b1;
               pc_inc  = 1'b1;
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            state_d = S_F0;
            unique case (opcode)
               OP_LDA: begin
                  mem_rd = 1'b1;
                  acc_en = 1'b1;
                  alu_op = 2'b00;
               end
               OP_STA: begin
                  acc_out = 1'b1;
                  mem_wr  = 1'b1;
               end
               OP_ADD: begin
                  mem_rd = 1'b1;
                  acc_en = 1'b1;
                  alu_op = 2'b01;
               end
               OP_SUB: begin
                  mem_rd = 1'b1;
                  acc_en = 1'b1;
                  alu_op = 2'b10;
               end
               default: ;
            endcase
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) state_d = S_CLEAR;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a small datapath model (PC, MAR, IR, ACC,
// memory) follows the DUT's enables, while an instruction-level model of
// each program predicts the control word expected on every cycle.
module tb_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [4:0] opcode;
   logic       zero;
   logic       sclr, pc_out, pc_inc, pc_load, mar_en, ir_en;
   logic       mem_rd, mem_wr, acc_en, acc_out, busy, halted, illegal;
   logic [1:0] alu_op;

   always #5 clk = ~clk;

   ctrl_sequencer #(.N(8)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
`ifdef CTRL_SINGLE_STEP_EN
      .step(1'b1),
`endif
      .sclr(sclr), .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load),
      .mar_en(mar_en), .ir_en(ir_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .acc_en(acc_en), .acc_out(acc_out), .alu_op(alu_op), .busy(busy),
      .halted(halted), .illegal(illegal)
   );

   // Control word bit masks.
   localparam logic [14:0] B_SCLR = 15'h4000, B_PCO = 15'h2000, B_PCI = 15'h1000,
                           B_PCL  = 15'h0800, B_MAR = 15'h0400, B_IR  = 15'h0200,
                           B_MRD  = 15'h0100, B_MWR = 15'h0080, B_ACE = 15'h0040,
                           B_ACO  = 15'h0020, B_ALU1 = 15'h0008, B_ALU2 = 15'h0010,
                           B_BUSY = 15'h0004, B_HLT = 15'h0002, B_ILL = 15'h0001;

   logic [14:0] cw;
   assign cw = {sclr, pc_out, pc_inc, pc_load, mar_en, ir_en, mem_rd, mem_wr,
                acc_en, acc_out, alu_op, busy, halted, illegal};

   // ---------------- datapath model driven by the DUT ----------------
   logic [7:0] mem [256];
   logic [7:0] prog [256];
   logic       ld_prog;
   logic [7:0] pc = 8'h00, mar = 8'h00, ir = 8'h00, acc = 8'h00;
   logic [7:0] bus, alu;

   always_comb begin
      bus = 8'h00;
      if (pc_out)       bus = pc;
      else if (mem_rd)  bus = mem[mar];
      else if (acc_out) bus = acc;
      alu = bus;
      if (alu_op == 2'b01)      alu = acc + bus;
      else if (alu_op == 2'b10) alu = acc - bus;
   end

   assign opcode = ir[7:3];
   assign zero   = (acc == 8'h00);

   always @(posedge clk) begin
      if (ld_prog) for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      if (sclr) begin
         pc <= 8'h00; mar <= 8'h00; ir <= 8'h00; acc <= 8'h00;
      end else begin
         if (mar_en) mar <= bus;
         if (ir_en)  ir  <= bus;
         if (pc_load)     pc <= bus;
         else if (pc_inc) pc <= pc + 8'd1;
         if (acc_en) acc <= alu;
         if (mem_wr) mem[mar] <= bus;
      end
   end

   // ---------------- checking ----------------
   logic [14:0] exp_q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int ill_cnt, wr_cnt, ace_cnt;
   logic [7:0] iss_acc;

   task automatic chk(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   // One clock: compare the control word against the model at the
   // falling edge, then release the stimulus 1 time unit later.
   task automatic tick();
      logic [14:0] w;
      @(negedge clk);
      cyc++;
      if (illegal) ill_cnt++;
      if (mem_wr)  wr_cnt++;
      if (acc_en)  ace_cnt++;
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         n_cmp++;
         if (cw !== w) begin
            n_bad++;
            $display("FAIL ctrl_word cyc=%0d: got %h, want %h", cyc, cw, w);
         end
      end
      #1;
   endtask

   // Instruction-level execution of prog, expanding each instruction
   // into the control words its phases must show.
   task automatic build_expect();
      logic [7:0] m [256];
      logic [7:0] ipc, iacc, a;
      logic [4:0] op;
      bit done;
      m = prog;
      ipc = 8'h00; iacc = 8'h00; done = 0;
      exp_q.push_back(B_SCLR | B_BUSY);
      for (int k = 0; k < 64 && !done; k++) begin
         op = m[ipc][7:3];
         exp_q.push_back(B_PCO | B_MAR | B_BUSY);
         exp_q.push_back(B_MRD | B_IR | B_PCI | B_BUSY);
         ipc = ipc + 8'd1;
         if (op == 5'd0) begin
            exp_q.push_back(B_BUSY);
         end else if (op == 5'd31) begin
            exp_q.push_back(B_BUSY);
            exp_q.push_back(B_HLT);
            exp_q.push_back(B_HLT);
            done = 1;
         end else if (op > 5'd6) begin
            exp_q.push_back(B_BUSY | B_ILL);
         end else begin
            exp_q.push_back(B_PCO | B_MAR | B_BUSY);
            a = m[ipc];
            if (op == 5'd5 || (op == 5'd6 && iacc == 8'h00)) begin
               exp_q.push_back(B_MRD | B_PCL | B_BUSY);
               ipc = a;
            end else if (op == 5'd6) begin
               exp_q.push_back(B_PCI | B_BUSY);
               ipc = ipc + 8'd1;
            end else begin
               exp_q.push_back(B_MRD | B_MAR | B_PCI | B_BUSY);
               ipc = ipc + 8'd1;
               case (op)
                  5'd1: begin exp_q.push_back(B_MRD | B_ACE | B_BUSY); iacc = m[a]; end
                  5'd2: begin exp_q.push_back(B_ACO | B_MWR | B_BUSY); m[a] = iacc; end
                  5'd3: begin exp_q.push_back(B_MRD | B_ACE | B_ALU1 | B_BUSY); iacc = iacc + m[a]; end
                  default: begin exp_q.push_back(B_MRD | B_ACE | B_ALU2 | B_BUSY); iacc = iacc - m[a]; end
               endcase
            end
         end
      end
      iss_acc = iacc;
   endtask

   task automatic load(input logic [7:0] img [256]);
      prog = img;
      ld_prog = 1'b1;
      tick();
      ld_prog = 1'b0;
   endtask

   // Start the loaded program; lat = clocks from start sample to HALT.
   task automatic go(output int lat);
      int c0;
      ill_cnt = 0; wr_cnt = 0; ace_cnt = 0;
      build_expect();
      start = 1'b1;
      c0 = cyc;
      lat = -1;
      for (int k = 0; k < 300 && lat < 0; k++) begin
         tick();
         start = 1'b0;
         if (halted) lat = cyc - c0;
      end
      if (lat < 0) chk("halt_timeout", 0, 1);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
      chk("trace_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   logic [7:0] img [256];
   int lat;
   bit found;

   initial begin
      rst = 1'b0; start = 1'b0; ld_prog = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = 8'h00;
      #3;
      chk("reset_outputs", cw, 0);
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      chk("idle_outputs", cw, 0);

      // LDA 0x10; ADD 0x11; HLT
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[0] = 8'h08; img[1] = 8'h10; img[2] = 8'h18; img[3] = 8'h11; img[4] = 8'hF8;
      img[8'h10] = 8'h05; img[8'h11] = 8'h03;
      load(img);
      go(lat);
      chk("p1_latency", lat, 15);
      chk("p1_acc", acc, 8'h08);
      chk("p1_model_acc", iss_acc, 8'h08);

      // JZ 0x20 taken (ACC cleared); HLT at 0x20
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[0] = 8'h30; img[1] = 8'h20; img[8'h20] = 8'hF8;
      load(img);
      go(lat);
      chk("jz_taken_latency", lat, 9);
      chk("jz_taken_mar", mar, 8'h20);
      chk("jz_taken_pc", pc, 8'h21);

      // LDA 0x10 (=5); JZ 0x20 not taken; HLT
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[0] = 8'h08; img[1] = 8'h10; img[2] = 8'h30; img[3] = 8'h20; img[4] = 8'hF8;
      img[8'h10] = 8'h05; img[8'h20] = 8'hF8;
      load(img);
      go(lat);
      chk("jz_fall_latency", lat, 14);
      chk("jz_fall_pc", pc, 8'h05);

      // Undefined opcode 01010 then HLT
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[0] = 8'h50; img[1] = 8'hF8;
      load(img);
      go(lat);
      chk("illegal_latency", lat, 8);
      chk("illegal_pulses", ill_cnt, 1);
      chk("illegal_no_wr", wr_cnt, 0);
      chk("illegal_no_acc", ace_cnt, 0);

      // LDA 0x10; SUB 0x11; STA 0x13; JMP 0x0C; HLT at 0x0C
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[0] = 8'h08; img[1] = 8'h10; img[2] = 8'h20; img[3] = 8'h11;
      img[4] = 8'h10; img[5] = 8'h13; img[6] = 8'h28; img[7] = 8'h0C;
      img[8'h0C] = 8'hF8; img[8'h10] = 8'h05; img[8'h11] = 8'h03;
      load(img);
      go(lat);
      chk("p6_latency", lat, 24);
      chk("p6_acc", acc, 8'h02);
      chk("p6_mem13", mem[8'h13], 8'h02);

      // LDA 0x10; STA 0x12; HLT, with reset dropped during the STA execute
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[0] = 8'h08; img[1] = 8'h10; img[2] = 8'h10; img[3] = 8'h12; img[4] = 8'hF8;
      img[8'h10] = 8'h05;
      load(img);
      build_expect();
      start = 1'b1;
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         tick();
         start = 1'b0;
         if (mem_wr) found = 1;
      end
      chk("sta_reached", found, 1);
      rst = 1'b0;
      #1;
      chk("rst_kills_wr", mem_wr, 0);
      chk("rst_outputs", cw, 0);
      exp_q.delete();
      tick(); tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("post_rst_idle", cw, 0);
      chk("sta_abandoned", mem[8'h12], 8'h00);
      go(lat);
      chk("sta_latency", lat, 15);
      chk("sta_mem12", mem[8'h12], 8'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
